// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serial data memory access controller.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes moved for an access size (1, 2, 4 or 8).
  function automatic logic [3:0] nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the core, bit 1 the loader.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // High when the loader won the previous grant, so the core is favoured next.
  logic last_ldr;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_ldr)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ldr <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_ldr <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates core/loader accesses and serialises them into little-endian byte
// cycles on the byte-wide data memory, returning extended load data with an ack.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 100,
  parameter int unsigned AW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [1:0]    core_size,
  input  logic          core_uns,
  input  logic [AW-1:0] core_addr,
  input  logic [63:0]   core_wdata,
  output logic          core_ack,
  output logic          core_err,
  output logic [63:0]   core_rdata,
  output logic          core_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [1:0]    ldr_size,
  input  logic          ldr_uns,
  input  logic [AW-1:0] ldr_addr,
  input  logic [63:0]   ldr_wdata,
  output logic          ldr_ack,
  output logic          ldr_err,
  output logic [63:0]   ldr_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata
);

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic          sel, sel_n;
  logic          we_q, we_n;
  logic [1:0]    size_q, size_n;
  logic          uns_q, uns_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [63:0]   wdata_q, wdata_n;
  logic [63:0]   ld_buf, ld_buf_n;

  logic [AW-1:0] mem_addr_n;
  logic [7:0]    mem_wdata_n;
  logic          mem_we_n, mem_re_n;
  logic          core_ack_n, core_err_n, ldr_ack_n, ldr_err_n;
  logic [63:0]   core_rdata_n, ldr_rdata_n;
  logic [63:0]   resp_data;

  logic [1:0]    req, gnt;
  logic          advance;
  logic          r_we, r_uns;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;
  logic          oor_c, last_c;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic uns);
    logic [63:0] r;
    case (sz)
      SZ_B:    r = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      SZ_H:    r = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_W:    r = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign req        = {ldr_req, core_req};
  assign core_stall = core_req & ~core_ack;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  // Winner's request fields, valid while a grant is being taken in IDLE.
  assign r_we    = gnt[1] ? ldr_we    : core_we;
  assign r_size  = gnt[1] ? ldr_size  : core_size;
  assign r_uns   = gnt[1] ? ldr_uns   : core_uns;
  assign r_addr  = gnt[1] ? ldr_addr  : core_addr;
  assign r_wdata = gnt[1] ? ldr_wdata : core_wdata;

  // One extra bit so base + N cannot wrap around the address space.
  assign oor_c  = ({1'b0, r_addr} + (AW+1)'(nbytes(r_size))) > (AW+1)'(DEPTH);
  assign last_c = (cnt == 3'(nbytes(size_q) - 4'd1));

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = sel;
    we_n         = we_q;
    size_n       = size_q;
    uns_n        = uns_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    ld_buf_n     = ld_buf;
    mem_addr_n   = '0;
    mem_wdata_n  = '0;
    mem_we_n     = 1'b0;
    mem_re_n     = 1'b0;
    core_ack_n   = 1'b0;
    core_err_n   = 1'b0;
    core_rdata_n = '0;
    ldr_ack_n    = 1'b0;
    ldr_err_n    = 1'b0;
    ldr_rdata_n  = '0;
    resp_data    = '0;
    advance      = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          advance  = 1'b1;
          sel_n    = gnt[1];
          we_n     = r_we;
          size_n   = r_size;
          uns_n    = r_uns;
          addr_n   = r_addr;
          wdata_n  = r_wdata;
          cnt_n    = '0;
          ld_buf_n = '0;
          if (oor_c) begin
            state_n = RESP;
            if (gnt[1]) begin
              ldr_ack_n = 1'b1;
              ldr_err_n = 1'b1;
            end else begin
              core_ack_n = 1'b1;
              core_err_n = 1'b1;
            end
          end else begin
            state_n     = XFER;
            mem_addr_n  = r_addr;
            mem_we_n    = r_we;
            mem_re_n    = ~r_we;
            mem_wdata_n = r_we ? r_wdata[7:0] : 8'd0;
          end
        end
      end
      XFER: begin
        if (!we_q) begin
          ld_buf_n[{cnt, 3'b000} +: 8] = mem_rdata;
        end
        if (last_c) begin
          state_n   = RESP;
          resp_data = we_q ? 64'd0 : extend(ld_buf_n, size_q, uns_q);
          if (sel) begin
            ldr_ack_n   = 1'b1;
            ldr_rdata_n = resp_data;
          end else begin
            core_ack_n   = 1'b1;
            core_rdata_n = resp_data;
          end
        end else begin
          cnt_n       = cnt + 3'd1;
          mem_addr_n  = addr_q + AW'(cnt_n);
          mem_we_n    = we_q;
          mem_re_n    = ~we_q;
          mem_wdata_n = we_q ? wdata_q[{cnt_n, 3'b000} +: 8] : 8'd0;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_buf     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
      ldr_ack    <= 1'b0;
      ldr_err    <= 1'b0;
      ldr_rdata  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      we_q       <= we_n;
      size_q     <= size_n;
      uns_q      <= uns_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      ld_buf     <= ld_buf_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_we     <= mem_we_n;
      mem_re     <= mem_re_n;
      core_ack   <= core_ack_n;
      core_err   <= core_err_n;
      core_rdata <= core_rdata_n;
      ldr_ack    <= ldr_ack_n;
      ldr_err    <= ldr_err_n;
      ldr_rdata  <= ldr_rdata_n;
    end
  end

endmodule
